// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake states and the arbiter
// FSM state encoding, plus a small helper to decode the RAM "data ready" state.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  // Only ACCESS completes a transfer; FREE, BUSY and ERROR all mean "keep waiting".
  function automatic logic ram_ready(input logic [1:0] st);
    return st == ACCESS;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two caches, the arbiter and the RAM.
// slave  : the arbiter's view (takes requests and RAM responses).
// master : the environment's view (caches and RAM model).
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  logic [1:0]        ramstate;

  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

endinterface

// File: rtl/arb_timer.sv
// Wait counter for a granted access. Held at zero outside a grant, counts
// every granted cycle the RAM is not in ACCESS, saturates instead of wrapping.
module arb_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear, count up, or hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: icache and dcache share one RAM port.
//
// state | meaning
// IDLE  | no grant; pick next requester, no RAM strobes
// IGNT  | icache owns the RAM port, waiting for ACCESS or timeout
// DGNT  | dcache owns the RAM port, waiting for ACCESS or timeout
// DONE  | one-cycle bubble after a completion, all strobes low
//
// Build option MEM_ARB_RR_EN: when defined, simultaneous requests alternate
// between the caches using a last-served flag; when undefined the dcache
// always wins and no last-served flag exists.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  arb_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       granted;
  logic       expired;
  logic       tmo;
  logic       d_req;
  logic       pick_d;

`ifdef MEM_ARB_RR_EN
  logic       last_d_q, last_d_d;   // 1: dcache was served last
`endif

  assign granted = (state_q == IGNT) || (state_q == DGNT);
  assign d_req   = bus.dREN | bus.dWEN;

`ifdef MEM_ARB_RR_EN
  assign pick_d = d_req && !(bus.iREN && last_d_q);
`else
  assign pick_d = d_req;
`endif

  arb_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr_i     (!granted),
    .inc_i     (granted && !ram_ready(bus.ramstate)),
    .expired_o (expired)
  );

  // Next-state and bus decode; strobes follow the live request so a drop
  // takes the strobe down in the same cycle.
  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    tmo          = 1'b0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
`ifdef MEM_ARB_RR_EN
    last_d_d     = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d = DGNT;
        end else if (bus.iREN) begin
          state_d = IGNT;
        end
      end
      IGNT: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr;
          if (ram_ready(bus.ramstate) || expired) begin
            bus.iwait = 1'b0;
            tmo       = !ram_ready(bus.ramstate);
            state_d   = DONE;
`ifdef MEM_ARB_RR_EN
            last_d_d  = 1'b0;
`endif
          end
        end
      end
      DGNT: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          bus.ramREN   = bus.dREN;
          bus.ramWEN   = bus.dWEN & ~bus.dREN;
          bus.ramaddr  = bus.daddr;
          bus.ramstore = bus.dstore;
          if (ram_ready(bus.ramstate) || expired) begin
            bus.dwait = 1'b0;
            tmo       = !ram_ready(bus.ramstate);
            state_d   = DONE;
`ifdef MEM_ARB_RR_EN
            last_d_d  = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (tmo) begin
      err_d = 1'b1;
    end
  end

  // State, sticky error and last-served registers, all cleared asynchronously.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
`ifdef MEM_ARB_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // Read data passes straight through, zeroed when the access timed out.
  assign bus.iload = tmo ? '0 : bus.ramload;
  assign bus.dload = tmo ? '0 : bus.ramload;
  assign bus.err   = err_q;

endmodule
